// File: rtl/noc_pkt_arbiter.sv
// noc_pkt_arbiter: round-robin arbiter that moves whole packets from four
// byte-wide sources onto one shared NoC byte bus. A grant is held until the
// source flags its last byte or the per-grant byte limit forces termination.
// After each packet the bus rests for IDLE_GAP cycles before the next grant.
module noc_pkt_arbiter #(
    parameter int IDLE_GAP = 1,
    parameter int MAX_PKT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] src_data,
    input  logic [3:0]  src_ctl,
    input  logic [3:0]  src_last,
    output logic [3:0]  pop,
    output logic [3:0]  grant,
    output logic        noc_from_dev_ctl,
    output logic [7:0]  noc_from_dev_data,
    output logic        busy,
    output logic        err_trunc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic        r_ctl;
    logic [7:0]  r_data;
    logic        r_err;
    logic [7:0]  r_byte_cnt;
    logic [3:0]  r_gap_cnt;
    logic [1:0]  r_last_ptr;

    logic [1:0]  w_winner;
    logic [1:0]  w_gidx;
    logic [7:0]  w_sel_data;
    logic        w_sel_ctl;
    logic        w_sel_last;
    logic        w_at_max;
    logic        w_end;

    // First requester found searching upward (mod 4) from last+1; the
    // previous owner itself is checked last so it has the lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req_v[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // One-hot grant to source index; zero grant maps to 0 and is never used.
    function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Winner selection and multiplexing of the granted source lane.
    always_comb begin
        w_winner   = rr_pick(req, r_last_ptr);
        w_gidx     = oh_to_idx(r_grant);
        w_sel_data = src_data[{w_gidx, 3'b000} +: 8];
        w_sel_ctl  = src_ctl[w_gidx];
        w_sel_last = src_last[w_gidx];
        w_at_max   = ((r_byte_cnt + 8'd1) == 8'(MAX_PKT));
        w_end      = w_sel_last | w_at_max;
    end

    // Pops follow the grant only while transferring; busy covers XFER and GAP.
    always_comb begin
        if (r_state == ST_XFER) begin
            pop = r_grant;
        end else begin
            pop = 4'b0000;
        end
        if (r_state != ST_IDLE) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

    assign grant             = r_grant;
    assign noc_from_dev_ctl  = r_ctl;
    assign noc_from_dev_data = r_data;
    assign err_trunc         = r_err;

    // Arbitration FSM with registered bus, grant and truncation-error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 4'b0000;
            r_ctl      <= 1'b1;
            r_data     <= 8'h00;
            r_err      <= 1'b0;
            r_byte_cnt <= 8'd0;
            r_gap_cnt  <= 4'd0;
            r_last_ptr <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ctl  <= 1'b1;
                    r_data <= 8'h00;
                    r_err  <= 1'b0;
                    if (req != 4'b0000) begin
                        r_grant    <= 4'b0001 << w_winner;
                        r_byte_cnt <= 8'd0;
                        r_state    <= ST_XFER;
                    end else begin
                        r_grant <= 4'b0000;
                    end
                end
                ST_XFER: begin
                    r_ctl      <= w_sel_ctl;
                    r_data     <= w_sel_data;
                    r_byte_cnt <= r_byte_cnt + 8'd1;
                    // A genuine last byte at the limit is a normal end.
                    r_err      <= w_at_max & ~w_sel_last;
                    if (w_end) begin
                        r_grant    <= 4'b0000;
                        r_last_ptr <= w_gidx;
                        if (IDLE_GAP > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= 4'(IDLE_GAP);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_XFER;
                    end
                end
                ST_GAP: begin
                    r_ctl  <= 1'b1;
                    r_data <= 8'h00;
                    r_err  <= 1'b0;
                    if (r_gap_cnt <= 4'd1) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= 4'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 4'b0000;
                    r_ctl   <= 1'b1;
                    r_data  <= 8'h00;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_pkt_arbiter.sv
// Self-checking bench for noc_pkt_arbiter: a vector table for the default
// configuration plus hand-written sequences for truncation, zero idle gap
// and reset during a transfer.
module tb_noc_pkt_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] src_data = 32'h0;
    logic [3:0]  src_ctl = 4'b0000;
    logic [3:0]  src_last = 4'b0000;

    logic [3:0]  a_pop, a_grant, b_pop, b_grant;
    logic        a_ctl, a_busy, a_err, b_ctl, b_busy, b_err;
    logic [7:0]  a_data, b_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Default configuration: IDLE_GAP=1, MAX_PKT=64.
    noc_pkt_arbiter dut_a (
        .clk(clk), .reset(reset), .req(req), .src_data(src_data),
        .src_ctl(src_ctl), .src_last(src_last), .pop(a_pop), .grant(a_grant),
        .noc_from_dev_ctl(a_ctl), .noc_from_dev_data(a_data),
        .busy(a_busy), .err_trunc(a_err)
    );

    // Short-packet configuration: no idle gap, 4-byte limit.
    noc_pkt_arbiter #(.IDLE_GAP(0), .MAX_PKT(4)) dut_b (
        .clk(clk), .reset(reset), .req(req), .src_data(src_data),
        .src_ctl(src_ctl), .src_last(src_last), .pop(b_pop), .grant(b_grant),
        .noc_from_dev_ctl(b_ctl), .noc_from_dev_data(b_data),
        .busy(b_busy), .err_trunc(b_err)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  ctl;
        logic [3:0]  last;
        logic [18:0] exp;   // {pop, grant, ctl, data, busy, err}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [31:0] d,
                       input logic [3:0] c, input logic [3:0] l,
                       input logic [3:0] ep, input logic [3:0] eg, input logic ec,
                       input logic [7:0] ed, input logic eb, input logic ee);
        vec_t v;
        v.rst = r; v.req = q; v.data = d; v.ctl = c; v.last = l;
        v.exp = {ep, eg, ec, ed, eb, ee};
        vecs.push_back(v);
    endtask

    // Apply inputs just after a rising edge, return at the following falling edge.
    task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] d,
                         input logic [3:0] c, input logic [3:0] l);
        @(posedge clk);
        #1;
        reset = r; req = q; src_data = d; src_ctl = c; src_last = l;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] outs_a();
        return {a_pop, a_grant, a_ctl, a_data, a_busy, a_err};
    endfunction

    // Single packet from source s on dut_b (MAX_PKT=4); last optionally on byte 4.
    task automatic run_len(input int s, input bit with_last, input int exp_err, input string tag);
        int npop, nerr, stray, popcyc, errcyc;
        logic [7:0] bytes[$];
        logic [3:0] q, l;
        logic [31:0] d;
        npop = 0; nerr = 0; stray = 0; popcyc = -1; errcyc = -1;
        drive(1'b1, 4'b0000, 32'h0, 4'b0000, 4'b0000);
        for (int c = 0; c < 12; c++) begin
            q = (npop < 4) ? (4'b0001 << s) : 4'b0000;
            d = 32'h0;
            d[8*s +: 8] = 8'h50 + 8'(npop);
            l = 4'b0000;
            if (with_last && npop == 3) l[s] = 1'b1;
            drive(1'b0, q, d, 4'b0000, l);
            if (b_pop == (4'b0001 << s)) begin
                npop++;
                if (npop == 4) popcyc = c;
            end else if (b_pop != 4'b0000) begin
                stray++;
            end
            if (b_err) begin
                nerr++;
                errcyc = c;
            end
            if (!b_ctl) bytes.push_back(b_data);
        end
        check({tag, " pops"}, npop, 4);
        check({tag, " stray pops"}, stray, 0);
        check({tag, " err pulses"}, nerr, exp_err);
        if (exp_err == 1) check({tag, " err timing"}, errcyc, popcyc + 1);
        check({tag, " bytes"}, bytes.size(), 4);
        for (int i = 0; i < bytes.size(); i++)
            check($sformatf("%s byte%0d", tag, i), {24'h0, bytes[i]}, 32'h50 + i);
        check({tag, " bus idle"}, {b_ctl, b_data, b_busy}, {1'b1, 8'h00, 1'b0});
    endtask

    initial begin
        int npop, nbytes, gaprun;
        logic [31:0] bb;
        bb = 32'h4131_2111;

        // Default config: source 0 3-byte packet, then source 2 2-byte packet.
        add(0, 4'b0101, 32'h00C1_00A1, 4'b0001, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(0, 4'b0101, 32'h00C1_00A1, 4'b0001, 4'b0000, 4'h1, 4'h1, 1, 8'h00, 1, 0);
        add(0, 4'b0101, 32'h00C1_00A2, 4'b0000, 4'b0000, 4'h1, 4'h1, 1, 8'hA1, 1, 0);
        add(0, 4'b0101, 32'h00C1_00A3, 4'b0000, 4'b0001, 4'h1, 4'h1, 0, 8'hA2, 1, 0);
        add(0, 4'b0100, 32'h00C1_0000, 4'b0000, 4'b0000, 4'h0, 4'h0, 0, 8'hA3, 1, 0);
        add(0, 4'b0100, 32'h00C1_0000, 4'b0000, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(0, 4'b0100, 32'h00C1_0000, 4'b0000, 4'b0000, 4'h4, 4'h4, 1, 8'h00, 1, 0);
        add(0, 4'b0100, 32'h00C2_0000, 4'b0100, 4'b0100, 4'h4, 4'h4, 0, 8'hC1, 1, 0);
        add(0, 4'b0000, 32'h0,         4'b0000, 4'b0000, 4'h0, 4'h0, 1, 8'hC2, 1, 0);
        add(0, 4'b0000, 32'h0,         4'b0000, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(1, 4'b0000, 32'h0,         4'b0000, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        // All four requesting, 2-byte packets: grants rotate 0,1,2,3,0.
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h1, 4'h1, 1, 8'h00, 1, 0);
        add(0, 4'b1111, 32'h4131_2112, 4'b1110, 4'b0001, 4'h1, 4'h1, 1, 8'h11, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 0, 8'h12, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h2, 4'h2, 1, 8'h00, 1, 0);
        add(0, 4'b1111, 32'h4131_2211, 4'b1101, 4'b0010, 4'h2, 4'h2, 1, 8'h21, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 0, 8'h22, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h4, 4'h4, 1, 8'h00, 1, 0);
        add(0, 4'b1111, 32'h4132_2111, 4'b1011, 4'b0100, 4'h4, 4'h4, 1, 8'h31, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 0, 8'h32, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h8, 4'h8, 1, 8'h00, 1, 0);
        add(0, 4'b1111, 32'h4231_2111, 4'b0111, 4'b1000, 4'h8, 4'h8, 1, 8'h41, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 0, 8'h42, 1, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);
        add(0, 4'b1111, bb,            4'b1111, 4'b0000, 4'h1, 4'h1, 1, 8'h00, 1, 0);
        // Reset while source 0 is mid-packet: everything idle afterwards.
        add(1, 4'b1111, bb,            4'b1111, 4'b0000, 4'h1, 4'h1, 1, 8'h11, 1, 0);
        add(0, 4'b0000, 32'h0,         4'b0000, 4'b0000, 4'h0, 4'h0, 1, 8'h00, 0, 0);

        drive(1'b1, 4'b0000, 32'h0, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0000, 32'h0, 4'b0000, 4'b0000);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].ctl, vecs[i].last);
            check($sformatf("vec%0d", i), {13'h0, outs_a()}, {13'h0, vecs[i].exp});
        end

        // Reset on the 2nd byte of a source-1 packet; priority pointer must reset.
        drive(1'b1, 4'b0000, 32'h0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0001, 32'h0000_F0E0, 4'b0000, 4'b0001);
        check("rst seq idle", {13'h0, outs_a()}, {13'h0, 4'h0, 4'h0, 1'b1, 8'h00, 1'b0, 1'b0});
        drive(1'b0, 4'b0001, 32'h0000_F0E0, 4'b0000, 4'b0001);
        check("rst seq grant0", {28'h0, a_grant}, 32'h1);
        drive(1'b0, 4'b0010, 32'h0000_F000, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0010, 32'h0000_F000, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0010, 32'h0000_F000, 4'b0000, 4'b0000);
        check("rst seq grant1", {24'h0, a_pop, a_grant}, 32'h22);
        drive(1'b1, 4'b0010, 32'h0000_F100, 4'b0000, 4'b0000);
        check("rst seq byte1", {13'h0, outs_a()}, {13'h0, 4'h2, 4'h2, 1'b0, 8'hF0, 1'b1, 1'b0});
        drive(1'b0, 4'b0011, 32'h0000_F2E1, 4'b0000, 4'b0000);
        check("rst seq after", {13'h0, outs_a()}, {13'h0, 4'h0, 4'h0, 1'b1, 8'h00, 1'b0, 1'b0});
        drive(1'b0, 4'b0011, 32'h0000_F2E1, 4'b0000, 4'b0000);
        check("rst seq src0 first", {28'h0, a_grant}, 32'h1);

        // Truncation at MAX_PKT=4, then last coinciding with the limit.
        run_len(1, 1'b0, 1, "trunc");
        run_len(3, 1'b1, 0, "last_at_max");

        // IDLE_GAP=0: back-to-back 1-byte packets from source 2.
        drive(1'b1, 4'b0000, 32'h0, 4'b0000, 4'b0000);
        npop = 0; nbytes = 0; gaprun = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, (npop < 4) ? 4'b0100 : 4'b0000,
                  {8'h00, 8'h70 + 8'(npop), 16'h0000}, 4'b0000, 4'b0100);
            if (b_pop == 4'b0100) npop++;
            if (!b_ctl) begin
                if (nbytes > 0) check($sformatf("gap0 idle before byte%0d", nbytes), gaprun, 1);
                check($sformatf("gap0 byte%0d", nbytes), {24'h0, b_data}, 32'h70 + nbytes);
                nbytes++;
                gaprun = 0;
            end else begin
                gaprun++;
            end
        end
        check("gap0 pops", npop, 4);
        check("gap0 bytes", nbytes, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_pkt_arbiter.md
NOC_PKT_ARBITER -- requirements
Module: noc_pkt_arbiter

Interface
REQ-001 Parameter IDLE_GAP, default 1: number of idle bus cycles inserted after each packet, legal range 0..15.
REQ-002 Parameter MAX_PKT, default 64: maximum bytes popped per grant before forced termination, legal range 2..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  bit i high = source i holds at least one complete packet.
REQ-006 src_data  input  32  byte of source i on bits [8i+7:8i], valid whenever req[i] or grant[i] is high.
REQ-007 src_ctl  input  4  control bit accompanying each source byte.
REQ-008 src_last  input  4  bit i high = current byte of source i is the final byte of its packet.
REQ-009 pop  output  4  one-hot, combinational; bit i high = source i byte consumed this cycle.
REQ-010 grant  output  4  registered, one-hot or zero; current owner of the shared output.
REQ-011 noc_from_dev_ctl  output  1  registered shared-bus control bit.
REQ-012 noc_from_dev_data  output  8  registered shared-bus data byte.
REQ-013 busy  output  1  high in XFER and GAP states.
REQ-014 err_trunc  output  1  registered one-cycle pulse on forced packet termination.

Function
REQ-015 FSM states: IDLE, XFER, GAP; encoding is free.
REQ-016 In IDLE and GAP the bus SHALL drive ctl=1, data=8'h00, the idle symbol.
REQ-017 IDLE: when req!=0, select the winner by round-robin, searching upward (mod 4) from last_ptr+1; register grant=onehot(winner), clear byte_cnt, and go to XFER on the next edge.
REQ-018 IDLE with req==0 remains in IDLE with grant=0.
REQ-019 XFER: pop[g]=1 every cycle; on that edge, register noc_from_dev_data<=src_data[g] and noc_from_dev_ctl<=src_ctl[g]; byte_cnt+1.
REQ-020 Latency: req rising at edge N in IDLE gives grant at N+1, first pop during cycle N+1, and the first byte on the bus after edge N+2.
REQ-021 XFER with src_last[g]=1 at pop: last byte still forwarded; last_ptr<=g, grant<=0; go to GAP when IDLE_GAP>0, else to IDLE.
REQ-022 XFER reaching pop number MAX_PKT without src_last: that byte forwarded, err_trunc=1 for one cycle, and the same exit as REQ-021.
REQ-023 src_last and the MAX_PKT limit in the same cycle: treat as normal end, err_trunc=0.
REQ-024 req is not sampled in XFER; changes to non-granted req bits do not alter the grant.
REQ-025 GAP: gap counter loaded with IDLE_GAP on entry and decremented each cycle; leave for IDLE when it reaches 1.
REQ-026 With IDLE_GAP=0 and a pending req, the next grant SHALL be registered one cycle after the last pop; the bus emits exactly one idle cycle between packets.
REQ-027 pop SHALL be 0 in every state except XFER.
REQ-028 byte_cnt is 8 bits and never wraps, because MAX_PKT<=255 bounds it.

Reset
REQ-029 reset=1 at a clock edge forces: state=IDLE, grant=0, pop=0, noc_from_dev_ctl=1, noc_from_dev_data=0, busy=0, err_trunc=0, byte_cnt=0, gap counter=0, last_ptr=3 (source 0 has first priority).
REQ-030 Reset asserted mid-XFER abandons the packet with no error pulse; the bus shows idle on the next cycle.

Verification
REQ-031 After reset, req=4'b0101, source 0 sends a 3-byte packet -> grant=0001, bus shows 3 bytes in order, IDLE_GAP idle cycles, then grant=0100.
REQ-032 req=4'b1111 held, each packet 2 bytes -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-033 MAX_PKT=4, source 1 never asserts src_last -> exactly 4 pops, err_trunc pulses once, bus returns to ctl=1/data=00.
REQ-034 IDLE_GAP=0, source 2 sends back-to-back single-byte packets -> each byte separated by exactly one idle bus cycle.
REQ-035 Reset asserted on the 2nd byte of a 5-byte packet -> next cycle grant=0, pop=0, bus idle, err_trunc=0; after release source 0 wins first.
REQ-036 src_last coincides with byte MAX_PKT -> normal end, err_trunc stays 0.
